// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
// The tag destination field is sized for the largest supported register file
// (REG_W_MAX bits); narrower register numbers are zero-extended into it.
package hazard_pkg;

  localparam int REG_W_MAX = 8;

  // Stage indices of the tracked pipeline after issue.
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] dst;
    logic                 late;
  } hz_tag_t;

  // Register-number width for a register file of nreg entries.
  function automatic int reg_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Per-source hazard lookup: youngest-first search of the tag array, then the
// outstanding long op. Produces a forward hit, a RAW stall or neither.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_W    = 5,
  parameter int NSTAGE   = 3,
  parameter int LD_STAGE = 1
) (
  input  logic                   used,
  input  logic [REG_W-1:0]       src,
  input  hz_tag_t [NSTAGE-1:0]   tags,
  input  logic [NSTAGE*XLEN-1:0] stage_result,
  input  logic                   long_busy,
  input  logic [REG_W-1:0]       long_dst,
  input  logic                   long_done,
  input  logic [XLEN-1:0]        long_result,
  output logic                   hit,
  output logic                   stall,
  output logic [XLEN-1:0]        value
);

  logic [REG_W_MAX-1:0] src_ext;
  logic                 found;

  assign src_ext = REG_W_MAX'(src);

  // Priority lookup: the first matching stage wins, the long op is the fallback.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    hit   = 1'b0;
    stall = 1'b0;
    value = '0;
    found = 1'b0;
    if (used && (src != '0)) begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (!found && tags[i].valid && (tags[i].dst == src_ext)) begin
          found = 1'b1;
          if (tags[i].late && (i < LD_STAGE)) begin
            stall = 1'b1;
          end else begin
            hit   = 1'b1;
            value = stage_result[i*XLEN +: XLEN];
          end
        end
      end
      if (!found && long_busy && (long_dst == src)) begin
        if (long_done) begin
          hit   = 1'b1;
          value = long_result;
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight destination tags over NSTAGE stages plus
// one long-latency op, forwards operands or stalls decode.
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall/forward
// performance counters; otherwise both counter ports are tied to zero.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int NSTAGE   = 3,
  parameter  int NSRC     = 2,
  parameter  int LD_STAGE = 1,
  localparam int REG_W    = reg_w(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [NSRC*REG_W-1:0]  issue_src,
  input  logic [NSRC-1:0]        issue_src_used,
  input  logic [REG_W-1:0]       issue_dst,
  input  logic                   issue_wr,
  input  logic                   issue_late,
  input  logic                   issue_long,
  input  logic                   flush,
  input  logic                   hold,
  input  logic [NSTAGE*XLEN-1:0] stage_result,
  input  logic                   long_done,
  input  logic [XLEN-1:0]        long_result,
  output logic                   stall_out,
  output logic [NSRC-1:0]        fwd_hit,
  output logic [NSRC*XLEN-1:0]   fwd_value,
  output logic                   long_busy,
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_fwd_cnt
);

  hz_tag_t [NSTAGE-1:0] tag_q;
  hz_tag_t              new_tag;
  logic                 long_busy_q;
  logic [REG_W-1:0]     long_dst_q;
  logic [NSRC-1:0]      raw_stall;
  logic                 waw_stall;
  logic                 struct_stall;
  logic                 accept;

  // Per-source lookups.
  for (genvar k = 0; k < NSRC; k++) begin : g_src
    hazard_src_match #(
      .XLEN     (XLEN),
      .REG_W    (REG_W),
      .NSTAGE   (NSTAGE),
      .LD_STAGE (LD_STAGE)
    ) u_match (
      .used         (issue_src_used[k]),
      .src          (issue_src[k*REG_W +: REG_W]),
      .tags         (tag_q),
      .stage_result (stage_result),
      .long_busy    (long_busy_q),
      .long_dst     (long_dst_q),
      .long_done    (long_done),
      .long_result  (long_result),
      .hit          (fwd_hit[k]),
      .stall        (raw_stall[k]),
      .value        (fwd_value[k*XLEN +: XLEN])
    );
  end

  // Stall decision and acceptance are purely combinational from state and inputs.
  always_comb begin
    waw_stall     = issue_wr && long_busy_q && !long_done && (issue_dst == long_dst_q);
    struct_stall  = issue_long && long_busy_q && !long_done;
    stall_out     = issue_valid && ((|raw_stall) || waw_stall || struct_stall);
    accept        = issue_valid && !stall_out && !flush && !hold;
    new_tag.valid = accept && issue_wr && !issue_long && (issue_dst != '0);
    new_tag.dst   = REG_W_MAX'(issue_dst);
    new_tag.late  = accept && issue_late;
  end

  // Tag pipeline: shift one stage per clock unless frozen by hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the tag array is small and its valid bits gate every lookup, so it is reset in full.
      tag_q <= '0;
    end else if (!hold) begin
      // NOTE: non-blocking assignments make every stage take its predecessor's pre-edge value.
      tag_q[0] <= new_tag;
      for (int i = 1; i < NSTAGE; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Long op tracking: a new long accept wins over a same-cycle completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_busy_q <= 1'b0;
      long_dst_q  <= '0;
    end else if (accept && issue_long) begin
      long_busy_q <= 1'b1;
      long_dst_q  <= issue_dst;
    end else if (long_done) begin
      long_busy_q <= 1'b0;
    end
  end

  assign long_busy = long_busy_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fwd_cnt_q;

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_out && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (accept && (|fwd_hit) && (fwd_cnt_q != '1)) fwd_cnt_q <= fwd_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_fwd_cnt   = fwd_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a queue-based model of in-flight instructions.
module tb_hazard_scoreboard;

  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int NSTAGE   = 3;
  localparam int NSRC     = 2;
  localparam int LD_STAGE = 1;
  localparam int REG_W    = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   issue_valid;
  logic [NSRC*REG_W-1:0]  issue_src;
  logic [NSRC-1:0]        issue_src_used;
  logic [REG_W-1:0]       issue_dst;
  logic                   issue_wr;
  logic                   issue_late;
  logic                   issue_long;
  logic                   flush;
  logic                   hold;
  logic [NSTAGE*XLEN-1:0] stage_result;
  logic                   long_done;
  logic [XLEN-1:0]        long_result;
  logic                   stall_out;
  logic [NSRC-1:0]        fwd_hit;
  logic [NSRC*XLEN-1:0]   fwd_value;
  logic                   long_busy;
  logic [31:0]            perf_stall_cnt;
  logic [31:0]            perf_fwd_cnt;

  int n_checks = 0;
  int n_errors = 0;

  hazard_scoreboard #(
    .XLEN(XLEN), .NREG(NREG), .NSTAGE(NSTAGE), .NSRC(NSRC), .LD_STAGE(LD_STAGE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_src      (issue_src),
    .issue_src_used (issue_src_used),
    .issue_dst      (issue_dst),
    .issue_wr       (issue_wr),
    .issue_late     (issue_late),
    .issue_long     (issue_long),
    .flush          (flush),
    .hold           (hold),
    .stage_result   (stage_result),
    .long_done      (long_done),
    .long_result    (long_result),
    .stall_out      (stall_out),
    .fwd_hit        (fwd_hit),
    .fwd_value      (fwd_value),
    .long_busy      (long_busy),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  // Each accepted register-writing instruction is a record with its age in
  // stages since issue; it is visible to lookups while age < NSTAGE.
  typedef struct {
    int dst;
    bit late;
    int age;
  } rec_t;

  rec_t        pipe_q[$];
  bit          m_busy;
  int          m_ldst;
  int unsigned m_stall_cnt;
  int unsigned m_fwd_cnt;
  bit          e_stall;
  bit          e_hit[NSRC];
  logic [XLEN-1:0] e_val[NSRC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe_q.delete();
    m_busy      = 1'b0;
    m_ldst      = 0;
    m_stall_cnt = 0;
    m_fwd_cnt   = 0;
  endtask

  task automatic model_eval();
    bit raw;
    bit waw;
    bit str;
    int src;
    int best;
    raw = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      e_hit[k] = 1'b0;
      e_val[k] = '0;
      src = int'(issue_src[k*REG_W +: REG_W]);
      if (issue_src_used[k] && src != 0) begin
        best = -1;
        for (int j = 0; j < pipe_q.size(); j++) begin
          if (pipe_q[j].dst == src && pipe_q[j].age < NSTAGE &&
              (best < 0 || pipe_q[j].age < pipe_q[best].age)) best = j;
        end
        if (best >= 0) begin
          if (pipe_q[best].late && pipe_q[best].age < LD_STAGE) raw = 1'b1;
          else begin
            e_hit[k] = 1'b1;
            e_val[k] = stage_result[pipe_q[best].age*XLEN +: XLEN];
          end
        end else if (m_busy && m_ldst == src) begin
          if (long_done) begin
            e_hit[k] = 1'b1;
            e_val[k] = long_result;
          end else raw = 1'b1;
        end
      end
    end
    waw = issue_wr && m_busy && !long_done && (int'(issue_dst) == m_ldst);
    str = issue_long && m_busy && !long_done;
    e_stall = issue_valid && (raw || waw || str);
  endtask

  task automatic model_compare();
    check("stall_out", 64'(stall_out), 64'(e_stall));
    for (int k = 0; k < NSRC; k++) begin
      check($sformatf("fwd_hit[%0d]", k), 64'(fwd_hit[k]), 64'(e_hit[k]));
      check($sformatf("fwd_value[%0d]", k), 64'(fwd_value[k*XLEN +: XLEN]), 64'(e_val[k]));
    end
    check("long_busy", 64'(long_busy), 64'(m_busy));
    check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall_cnt));
    check("perf_fwd_cnt", 64'(perf_fwd_cnt), 64'(m_fwd_cnt));
  endtask

  task automatic model_commit();
    bit accept;
    bit any_hit;
    accept  = issue_valid && !e_stall && !flush && !hold;
    any_hit = 1'b0;
    for (int k = 0; k < NSRC; k++) any_hit |= e_hit[k];
`ifdef HAZARD_PERF_CNT_EN
    if (e_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    if (accept && any_hit && m_fwd_cnt != 32'hFFFF_FFFF) m_fwd_cnt++;
`endif
    if (!hold) begin
      for (int j = 0; j < pipe_q.size(); j++) pipe_q[j].age++;
      for (int j = pipe_q.size() - 1; j >= 0; j--)
        if (pipe_q[j].age >= NSTAGE) pipe_q.delete(j);
      if (accept && issue_wr && !issue_long && issue_dst != 0)
        pipe_q.push_front('{dst: int'(issue_dst), late: issue_late, age: 0});
    end
    if (accept && issue_long) begin
      m_busy = 1'b1;
      m_ldst = int'(issue_dst);
    end else if (long_done) begin
      m_busy = 1'b0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input int s0, input int s1, input bit [1:0] used,
                       input int dst, input bit wr, input bit late, input bit lng,
                       input bit fl, input bit hd, input bit ld, input logic [XLEN-1:0] lres);
    issue_valid    = v;
    issue_src      = {REG_W'(s1), REG_W'(s0)};
    issue_src_used = used;
    issue_dst      = REG_W'(dst);
    issue_wr       = wr;
    issue_late     = late;
    issue_long     = lng;
    flush          = fl;
    hold           = hd;
    long_done      = ld;
    long_result    = lres;
  endtask

  task automatic set_results(input logic [XLEN-1:0] r0, input logic [XLEN-1:0] r1,
                             input logic [XLEN-1:0] r2);
    stage_result = {r2, r1, r0};
  endtask

  // Move to the sampling point and run the per-cycle model comparison.
  task automatic eval_point();
    @(negedge clk);
    model_eval();
    model_compare();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    eval_point();
    advance();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, '0);
    set_results(32'h1, 32'h2, 32'h3);
    model_reset();
    #12;
    check("reset stall_out", 64'(stall_out), 64'd0);
    check("reset fwd_hit", 64'(fwd_hit), 64'd0);
    check("reset fwd_value", 64'(fwd_value), 64'd0);
    check("reset long_busy", 64'(long_busy), 64'd0);
    check("reset perf_stall", 64'(perf_stall_cnt), 64'd0);
    check("reset perf_fwd", 64'(perf_fwd_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: ALU result in EX forwarded to the next instruction.
    drive(1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0, 0, '0);
    cyc();
    drive(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, '0);
    set_results(32'h0000_0007, 32'h11, 32'h22);
    eval_point();
    check("t1 stall", 64'(stall_out), 64'd0);
    check("t1 hit0", 64'(fwd_hit[0]), 64'd1);
    check("t1 value0", 64'(fwd_value[31:0]), 64'h0000_0007);
    advance();

    // 2: load-use costs one stall cycle, then forwards from MEM.
    drive(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0, 0, '0);
    cyc();
    drive(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, '0);
    eval_point();
    check("t2 load-use stall", 64'(stall_out), 64'd1);
    advance();
    set_results(32'h33, 32'hDEAD_BEEF, 32'h44);
    eval_point();
    check("t2 stall released", 64'(stall_out), 64'd0);
    check("t2 value0", 64'(fwd_value[31:0]), 64'hDEAD_BEEF);
    advance();

    // 3: reader of a long op result stalls until long_done forwards it.
    drive(1, 0, 0, 2'b00, 8, 1, 0, 1, 0, 0, 0, '0);
    cyc();
    drive(1, 8, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, '0);
    for (int n = 0; n < 2; n++) begin
      eval_point();
      check("t3 long RAW stall", 64'(stall_out), 64'd1);
      check("t3 long_busy", 64'(long_busy), 64'd1);
      advance();
    end
    drive(1, 8, 0, 2'b01, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0120);
    eval_point();
    check("t3 done stall", 64'(stall_out), 64'd0);
    check("t3 done value", 64'(fwd_value[31:0]), 64'h0000_0120);
    advance();

    // 4: WAW and structural stalls against a busy long op.
    drive(1, 0, 0, 2'b00, 8, 1, 0, 1, 0, 0, 0, '0);
    cyc();
    drive(1, 0, 0, 2'b00, 8, 1, 0, 0, 0, 0, 0, '0);
    eval_point();
    check("t4 WAW stall", 64'(stall_out), 64'd1);
    advance();
    drive(1, 0, 0, 2'b00, 9, 1, 0, 1, 0, 0, 0, '0);
    eval_point();
    check("t4 structural stall", 64'(stall_out), 64'd1);
    advance();
    drive(1, 0, 0, 2'b00, 9, 1, 0, 1, 0, 0, 1, 32'h5);
    eval_point();
    check("t4 structural released", 64'(stall_out), 64'd0);
    advance();
    drive(1, 0, 0, 2'b00, 8, 1, 0, 0, 0, 0, 0, '0);
    eval_point();
    check("t4 busy with new op", 64'(long_busy), 64'd1);
    check("t4 no WAW on old dst", 64'(stall_out), 64'd0);
    advance();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 32'h6);
    cyc();

    // 5: youngest match wins; r0 never forwards.
    drive(1, 0, 0, 2'b00, 4, 1, 0, 0, 0, 0, 0, '0);
    cyc();
    drive(1, 0, 0, 2'b00, 6, 1, 0, 0, 0, 0, 0, '0);
    cyc();
    drive(1, 0, 0, 2'b00, 4, 1, 0, 0, 0, 0, 0, '0);
    cyc();
    drive(1, 4, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, '0);
    set_results(32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC);
    eval_point();
    check("t5 hit vector", 64'(fwd_hit), 64'b01);
    check("t5 youngest value", 64'(fwd_value[31:0]), 64'hAAAA_AAAA);
    advance();

    // 6: hold freezes tags; flush blocks entry; reset kills a long op.
    drive(1, 0, 0, 2'b00, 10, 1, 0, 0, 0, 0, 0, '0);
    cyc();
    drive(1, 10, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0, '0);
    set_results(32'h0000_0010, 32'h0000_0020, 32'h0000_0030);
    for (int n = 0; n < 3; n++) begin
      eval_point();
      check("t6 hold keeps EX value", 64'(fwd_value[31:0]), 64'h0000_0010);
      advance();
    end
    drive(1, 0, 0, 2'b00, 11, 1, 0, 0, 1, 0, 0, '0);
    cyc();
    drive(1, 11, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, '0);
    eval_point();
    check("t6 flushed no hit", 64'(fwd_hit[0]), 64'd0);
    advance();
    drive(1, 0, 0, 2'b00, 12, 1, 0, 1, 0, 0, 0, '0);
    cyc();
    drive(1, 12, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, '0);
    #2;
    check("t6 pre-reset stall", 64'(stall_out), 64'd1);
    rst = 1'b1;
    #1;
    check("t6 reset long_busy", 64'(long_busy), 64'd0);
    check("t6 reset stall", 64'(stall_out), 64'd0);
    model_reset();
    #1;
    rst = 1'b0;
    cyc();

    // Randomized traffic over a small register set to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 8,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 4) == 0,
            XLEN'($urandom));
      stage_result = {XLEN'($urandom), XLEN'($urandom), XLEN'($urandom)};
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
